// File: rtl/rat_path_replayer.sv
// rat_path_replayer: buffers the rat's move stream and replays it as (x,y) positions every STEP_DIV cycles.
// Optional BOUNDS_CHECK_EN: moves leaving 0..15 are skipped and flagged on bad_move instead of wrapping.
module rat_path_replayer #(
  parameter int DEPTH = 256,
  parameter int AW = 8,
  parameter int STEP_DIV = 4,
  parameter logic [3:0] START_X = 4'd0,
  parameter logic [3:0] START_Y = 4'd0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          move_valid,
  input  logic [1:0]    move,
  input  logic          rat_done,
  input  logic          rat_fail,
  output logic [3:0]    pos_x,
  output logic [3:0]    pos_y,
  output logic          pos_valid,
  output logic          busy,
  output logic          replay_done,
  output logic          path_fail,
  output logic          overflow,
  output logic [AW:0]   path_len
`ifdef BOUNDS_CHECK_EN
  ,
  output logic          bad_move
`endif
);
  localparam int CW = STEP_DIV > 1 ? $clog2(STEP_DIV) : 1;
  typedef enum logic [1:0] {CAPTURE, REPLAY, FINISH, FAILED} state_t;
  state_t state_q, state_d;
  logic [AW:0] len_q, len_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0] x_q, x_d, y_q, y_d, nx, ny;
  logic v_q, v_d, busy_q, busy_d, done_q, done_d, fail_q, fail_d, ovf_q, ovf_d;
  logic [1:0] mem [DEPTH];
  logic [1:0] rd_move;
  logic cap, full, step, more, enter, adv, apply, wr_en;
`ifdef BOUNDS_CHECK_EN
  logic bad_q, bad_d, oob;
`endif
  // path_len doubles as the write pointer; rd_q is AW+1 wide so a completely full buffer still replays
  always_comb begin
    rd_move = mem[rd_q[AW-1:0]];
    nx = x_q + 4'(rd_move == 2'b01) - 4'(rd_move == 2'b10);
    ny = y_q + 4'(rd_move == 2'b11) - 4'(rd_move == 2'b00);
    cap = state_q == CAPTURE;
    full = len_q == (AW+1)'(DEPTH);
    step = state_q == REPLAY && cnt_q == CW'(STEP_DIV - 1);
    more = rd_q != len_q;
    enter = cap && rat_done;
    adv = step && more;
    wr_en = cap && move_valid && !full;
    state_d = enter ? REPLAY : cap && rat_fail ? FAILED : step && !more ? FINISH : state_q;
    len_d = len_q + (AW+1)'(wr_en);
    ovf_d = ovf_q | (cap && move_valid && full);
    fail_d = fail_q | (cap && !rat_done && rat_fail);
    cnt_d = enter || step ? '0 : state_q == REPLAY ? cnt_q + CW'(1) : cnt_q;
    rd_d = rd_q + (AW+1)'(adv);
    v_d = enter || adv;
    busy_d = state_d == REPLAY;
    done_d = state_d == FINISH;
`ifdef BOUNDS_CHECK_EN
    oob = (rd_move == 2'b00 && y_q == 4'd0) || (rd_move == 2'b01 && x_q == 4'd15) ||
          (rd_move == 2'b10 && x_q == 4'd0) || (rd_move == 2'b11 && y_q == 4'd15);
    apply = adv && !oob;
    bad_d = bad_q | (adv && oob);
`else
    apply = adv;
`endif
    x_d = enter ? START_X : apply ? nx : x_q;
    y_d = enter ? START_Y : apply ? ny : y_q;
  end
  always_ff @(posedge clock) begin
    if (wr_en) mem[len_q[AW-1:0]] <= move;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= CAPTURE;
      len_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      x_q <= START_X;
      y_q <= START_Y;
      v_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fail_q <= 1'b0;
      ovf_q <= 1'b0;
`ifdef BOUNDS_CHECK_EN
      bad_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      v_q <= v_d;
      busy_q <= busy_d;
      done_q <= done_d;
      fail_q <= fail_d;
      ovf_q <= ovf_d;
`ifdef BOUNDS_CHECK_EN
      bad_q <= bad_d;
`endif
    end
  end
  assign pos_x = x_q;
  assign pos_y = y_q;
  assign pos_valid = v_q;
  assign busy = busy_q;
  assign replay_done = done_q;
  assign path_fail = fail_q;
  assign overflow = ovf_q;
  assign path_len = len_q;
`ifdef BOUNDS_CHECK_EN
  assign bad_move = bad_q;
`endif
endmodule

// File: tb/tb_rat_path_replayer.sv
// tb_rat_path_replayer: random and directed stimulus on two replayer configurations against a closed-form path model.
module tb_rat_path_replayer;
  logic clock = 1'b0, reset = 1'b0, move_valid = 1'b0, rat_done = 1'b0, rat_fail = 1'b0;
  logic [1:0] move = 2'b00;
  logic [3:0] px0, py0, px1, py1;
  logic v0, b0, d0, f0, o0, v1, b1, d1, f1, o1, bm0, bm1;
  logic [8:0] len0;
  logic [2:0] len1;
  int checks = 0, errors = 0, cyc = 0, n1 = 0;
  bit live = 0, rec = 0;
  int mode [2];
  int t [2];
  bit ovf [2];
  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  int rx [$];
  int ry [$];
  int rc [$];
  always #5 clock = ~clock;
  rat_path_replayer dut0 (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move(move), .rat_done(rat_done),
    .rat_fail(rat_fail), .pos_x(px0), .pos_y(py0), .pos_valid(v0), .busy(b0), .replay_done(d0),
    .path_fail(f0), .overflow(o0), .path_len(len0)
`ifdef BOUNDS_CHECK_EN
    , .bad_move(bm0)
`endif
  );
  rat_path_replayer #(.DEPTH(4), .AW(2), .STEP_DIV(3), .START_X(4'd3), .START_Y(4'd14)) dut1 (
    .clock(clock), .reset(reset), .move_valid(move_valid), .move(move), .rat_done(rat_done),
    .rat_fail(rat_fail), .pos_x(px1), .pos_y(py1), .pos_valid(v1), .busy(b1), .replay_done(d1),
    .path_fail(f1), .overflow(o1), .path_len(len1)
`ifdef BOUNDS_CHECK_EN
    , .bad_move(bm1)
`endif
  );
`ifndef BOUNDS_CHECK_EN
  assign bm0 = 1'b0;
  assign bm1 = 1'b0;
`endif
  // expected outputs as a function of replay age: one position every sd cycles, then done
  function automatic logic [22:0] exp_vec(int md, int tt, bit ov, logic [1:0] q[$], int sx, int sy, int sd);
    int n = q.size();
    int k = tt / sd;
    int kk = k < n ? k : n;
    int x = sx, y = sy, dx, dy;
    bit bad = 0, v, b, d;
    if (md == 1)
      for (int j = 0; j < kk; j++) begin
        dx = q[j] == 2'b01 ? 1 : q[j] == 2'b10 ? -1 : 0;
        dy = q[j] == 2'b00 ? -1 : q[j] == 2'b11 ? 1 : 0;
`ifdef BOUNDS_CHECK_EN
        if (x + dx < 0 || x + dx > 15 || y + dy < 0 || y + dy > 15) bad = 1;
        else begin x += dx; y += dy; end
`else
        x = (x + dx + 16) % 16;
        y = (y + dy + 16) % 16;
`endif
      end
    v = md == 1 && tt % sd == 0 && k <= n;
    b = md == 1 && tt < (n + 1) * sd;
    d = md == 1 && !b;
    return {4'(x), 4'(y), v, b, d, md == 2, ov, bad, 9'(n)};
  endfunction
  always @(posedge clock) begin
    cyc++;
    if (reset) begin q0.delete(); q1.delete(); end
    for (int i = 0; i < 2; i++) begin
      if (reset) begin mode[i] = 0; t[i] = 0; ovf[i] = 0; end
      else if (mode[i] == 0) begin
        if (move_valid) begin
          if (i == 0 && q0.size() < 256) q0.push_back(move);
          else if (i == 1 && q1.size() < 4) q1.push_back(move);
          else ovf[i] = 1;
        end
        if (rat_done) begin mode[i] = 1; t[i] = 0; end
        else if (rat_fail) mode[i] = 2;
      end else if (mode[i] == 1) t[i]++;
    end
  end
  always @(negedge clock) if (live) begin
    logic [22:0] e, a;
    e = exp_vec(mode[0], t[0], ovf[0], q0, 0, 0, 4);
    a = {px0, py0, v0, b0, d0, f0, o0, bm0, len0};
    checks++;
    if (a !== e) begin errors++; $display("FAIL cyc%0d dut0 outputs got %h expected %h", cyc, a, e); end
    e = exp_vec(mode[1], t[1], ovf[1], q1, 3, 14, 3);
    a = {px1, py1, v1, b1, d1, f1, o1, bm1, 6'd0, len1};
    checks++;
    if (a !== e) begin errors++; $display("FAIL cyc%0d dut1 outputs got %h expected %h", cyc, a, e); end
  end
  always @(negedge clock) if (rec) begin
    if (v0) begin rx.push_back(px0); ry.push_back(py0); rc.push_back(cyc); end
    if (v1) n1++;
  end
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act !== exp) begin errors++; $display("FAIL %s got %0d expected %0d", nm, act, exp); end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic do_reset();
    reset = 1; move_valid = 0; rat_done = 0; rat_fail = 0;
    tick();
    reset = 0;
    rx.delete(); ry.delete(); rc.delete(); n1 = 0;
  endtask
  task automatic send(logic [1:0] m);
    move_valid = 1; move = m;
    tick();
    move_valid = 0;
  endtask
  task automatic finish_done();
    rat_done = 1;
    tick();
    rat_done = 0;
  endtask
  initial begin
    int n, r;
    do_reset();
    live = 1;
    chk("reset_x", px0, 0); chk("reset_len", len0, 0); chk("reset_x1", px1, 3); chk("reset_y1", py1, 14);
    rec = 1;
    send(2'b01); send(2'b01); send(2'b11); send(2'b11);
    finish_done();
    repeat (25) tick();
    chk("t1_len", len0, 4); chk("t1_x", px0, 2); chk("t1_y", py0, 2);
    chk("t1_done", d0, 1); chk("t1_busy", b0, 0); chk("t1_nvalid", rx.size(), 5);
    if (rx.size() == 5)
      for (int i = 0; i < 5; i++) begin
        chk("t1_px", rx[i], i < 2 ? i : 2);
        chk("t1_py", ry[i], i < 3 ? 0 : i - 2);
        if (i > 0) chk("t1_spacing", rc[i] - rc[i-1], 4);
      end
    do_reset();
    send(2'b01); send(2'b11); send(2'b01);
    rat_fail = 1; tick(); rat_fail = 0;
    rat_done = 1; tick(); rat_done = 0;
    repeat (10) tick();
    chk("t2_fail", f0, 1); chk("t2_busy", b0, 0); chk("t2_x", px0, 0);
    chk("t2_nvalid0", rx.size(), 0); chk("t2_nvalid1", n1, 0);
    do_reset();
    repeat (5) send(2'b01);
    finish_done();
    repeat (30) tick();
    chk("t3_ovf1", o1, 1); chk("t3_len1", len1, 4); chk("t3_ovf0", o0, 0);
    chk("t3_len0", len0, 5); chk("t3_nvalid1", n1, 5); chk("t3_x1", px1, 7);
    do_reset();
    send(2'b00); send(2'b01);
    finish_done();
    repeat (15) tick();
    chk("t4_x", px0, 1);
`ifdef BOUNDS_CHECK_EN
    chk("t4_y", py0, 0); chk("t4_bad", bm0, 1);
`else
    chk("t4_y", py0, 15);
`endif
    do_reset();
    send(2'b01); send(2'b11); send(2'b01); send(2'b11);
    finish_done();
    repeat (8) tick();
    chk("t5_mid_x", px0, 1); chk("t5_mid_y", py0, 1); chk("t5_mid_busy", b0, 1);
    reset = 1; tick(); reset = 0;
    chk("t5_x", px0, 0); chk("t5_y", py0, 0); chk("t5_len", len0, 0);
    chk("t5_busy", b0, 0); chk("t5_done", d0, 0); chk("t5_x1", px1, 3);
    send(2'b01);
    chk("t5_capture", len0, 1);
    do_reset();
    send(2'b01);
    move_valid = 1; move = 2'b11; rat_done = 1;
    tick();
    move_valid = 0; rat_done = 0;
    repeat (15) tick();
    chk("t6_len", len0, 2); chk("t6_x", px0, 1); chk("t6_y", py0, 1);
    rec = 0;
    for (int it = 0; it < 40; it++) begin
      do_reset();
      n = it == 7 ? 260 : $urandom_range(0, 12);
      for (int j = 0; j < n; j++) begin
        if (it != 7) repeat ($urandom_range(0, 2)) tick();
        send(2'($urandom));
      end
      r = $urandom_range(0, 3);
      rat_done = r != 0; rat_fail = r == 0 || r == 2;
      move_valid = $urandom_range(0, 1); move = 2'($urandom);
      tick();
      for (int j = 0; j < ((n < 256 ? n : 256) + 2) * 4 + 5; j++) begin
        move_valid = $urandom_range(0, 1); move = 2'($urandom);
        rat_done = $urandom_range(0, 1); rat_fail = $urandom_range(0, 1);
        reset = $urandom_range(0, 199) == 0;
        tick();
      end
      reset = 0; move_valid = 0; rat_done = 0; rat_fail = 0;
    end
    live = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rat_path_replayer.md
Name: rat_path_replayer

Overview:
- Sits directly downstream of the intelligent-rat top; consumes its Move stream plus Done/Fail.
- Buffers the solved path, then replays it one step per STEP_DIV cycles as absolute (x,y) maze coordinates for display/checker logic.
- Reports path length and overflow, and flags an invalid path on rat failure.

Parameters:
- DEPTH, 256, move buffer entries (power of 2).
- AW, 8, buffer address width; log2(DEPTH).
- STEP_DIV, 4, clock cycles between replayed positions (>=1).
- START_X, 0, replay start x (4-bit).
- START_Y, 0, replay start y (4-bit).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- move_valid  in  1  one-cycle strobe; move is valid this cycle.
- move  in  2  rat move code: 00 up (y-1), 01 right (x+1), 10 left (x-1), 11 down (y+1).
- rat_done  in  1  rat solved maze (level, sampled).
- rat_fail  in  1  rat found no path (level, sampled).
- pos_x  out  4  current replay x.
- pos_y  out  4  current replay y.
- pos_valid  out  1  one-cycle strobe per new position (including start).
- busy  out  1  high in REPLAY.
- replay_done  out  1  sticky; path fully replayed.
- path_fail  out  1  sticky; rat failed, no replay.
- overflow  out  1  sticky; move arrived with buffer full.
- path_len  out  AW+1  moves captured.

Behaviour:
- Reset: all outputs 0 except pos_x=START_X, pos_y=START_Y; state CAPTURE; write/read pointers 0; step counter 0.
- Synchronous reset dominates every other input, in any state including mid-replay.
- CAPTURE: each move_valid writes move at wr_ptr, wr_ptr++, path_len++. If path_len==DEPTH, the move is dropped and overflow is set; path_len saturates at DEPTH.
- CAPTURE -> REPLAY on rat_done=1 (rat_done wins if asserted with rat_fail). A move_valid in the same cycle as rat_done is still captured.
- CAPTURE -> FAILED on rat_fail=1 with rat_done=0: path_fail=1, positions unchanged.
- REPLAY entry cycle: pos_x/pos_y loaded with START_X/START_Y, pos_valid=1, busy=1, step counter cleared.
- REPLAY: when counter reaches STEP_DIV-1, counter clears. If rd_ptr!=wr_ptr, read buffer[rd_ptr], apply delta to pos_x/pos_y, rd_ptr++, pos_valid=1 for that cycle. Otherwise -> FINISH.
- Buffer read is combinational from registered pointer. New position visible the cycle after the step event.
- Coordinate arithmetic: 4-bit modulo, so 0-1 wraps to 15 and 15+1 wraps to 0, unless BOUNDS_CHECK_EN is defined.
- Zero-length path (rat_done with no moves): one pos_valid at start, then FINISH after STEP_DIV cycles.
- FINISH: busy=0, replay_done=1; terminal until reset. move_valid ignored.
- FAILED: terminal until reset. move_valid, rat_done ignored.
- move_valid in REPLAY is ignored and sets no flag.

Optional Feature:
- BOUNDS_CHECK_EN
- Defined: a replayed move that would leave 0..15 is not applied. Position holds, pos_valid still pulses, and sticky output bad_move (1 bit, reset 0) is set; replay continues.
- Not defined: bad_move port absent; coordinates wrap modulo 16.

Test Plan:
- Reset, strobe moves 01,01,11,11, then rat_done -> path_len=4; positions (0,0),(0,1)... exactly: (0,0),(1,0),(2,0),(2,1),(2,2), pos_valid spaced 4 cycles; then replay_done=1, busy=0.
- rat_fail with no rat_done after 3 moves -> path_fail=1, busy never 1, pos stays (0,0), no pos_valid.
- Fill DEPTH=4 build with 5 moves -> overflow=1, path_len=4, replay emits 4 steps only.
- Move 00 from (0,0), no macro -> pos_y=15. With BOUNDS_CHECK_EN -> pos_y=0, bad_move=1, later moves still replayed.
- Assert reset mid-REPLAY after 2 steps -> next cycle pos=(START_X,START_Y), all flags 0, path_len=0, state CAPTURE.
- rat_done and move_valid in same cycle -> move captured (path_len incremented), replay includes it.
